// File: rtl/alu_pkg.sv
// Opcode and FSM encodings shared by the sequential execute unit.
// Helpers classify long (iterative) ops and operand signedness.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_SLT    = 5'd8,
      OP_SLTU   = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17,
      OP_CTZ    = 5'd18,
      OP_CLZ    = 5'd19,
      OP_CPOP   = 5'd20
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIXUP
   } state_e;

   function automatic logic is_mul(op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

   function automatic logic is_div(op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic is_long_op(op_e op);
      return is_mul(op) || is_div(op);
   endfunction

   function automatic logic is_signed_a(op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(op_e op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue and result handshake bundle of the execute unit.
// master = pipeline side, slave = execute unit.
interface alu_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Radix-2 multiply / restoring-divide datapath on unsigned magnitudes.
// Signs are re-applied combinationally for the FIXUP write.
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clr,
   input  logic            i_start,
   input  logic            i_step,
   input  op_e             i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_last,
   output logic [XLEN-1:0] o_result
);
   localparam int SW = $clog2(XLEN);

   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_m;
   logic [SW-1:0]     r_cnt;
   op_e               r_op;
   logic              r_nq;
   logic              r_nr;

   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_ma;
   logic [XLEN-1:0]   w_mb;
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_mstep;
   logic [XLEN:0]     w_rs;
   logic [XLEN:0]     w_df;
   logic              w_qb;
   logic [2*XLEN-1:0] w_dstep;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_q;
   logic [XLEN-1:0]   w_r;

   assign w_sa = is_signed_a(i_op) & i_a[XLEN-1];
   assign w_sb = is_signed_b(i_op) & i_b[XLEN-1];
   assign w_ma = w_sa ? -i_a : i_a;
   assign w_mb = w_sb ? -i_b : i_b;

   // MUL: acc = {partial product, remaining multiplier bits}
   assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                + (r_acc[0] ? {1'b0, r_m} : '0);
   assign w_mstep = {w_sum, r_acc[XLEN-1:1]};

   // DIV: acc = {partial remainder, dividend/quotient bits}
   assign w_rs = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_df = w_rs - {1'b0, r_m};
   assign w_qb = ~w_df[XLEN];
   assign w_dstep = {w_qb ? w_df[XLEN-1:0] : w_rs[XLEN-1:0],
                     r_acc[XLEN-2:0], w_qb};

   assign o_last = i_step & (r_cnt == SW'(XLEN - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_acc <= '0;
         r_m   <= '0;
         r_cnt <= '0;
         r_op  <= OP_ADD;
         r_nq  <= 1'b0;
         r_nr  <= 1'b0;
      end else if (i_start) begin
         r_acc <= is_mul(i_op) ? {{XLEN{1'b0}}, w_mb}
                               : {{XLEN{1'b0}}, w_ma};
         r_m   <= is_mul(i_op) ? w_ma : w_mb;
         r_cnt <= '0;
         r_op  <= i_op;
         r_nq  <= w_sa ^ w_sb;
         r_nr  <= w_sa;
      end else if (i_step) begin
         r_acc <= is_mul(r_op) ? w_mstep : w_dstep;
         r_cnt <= r_cnt + SW'(1);
      end
   end

   assign w_prod = r_nq ? -r_acc : r_acc;
   assign w_q = r_nq ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_r = r_nr ? -r_acc[2*XLEN-1:XLEN]
                     : r_acc[2*XLEN-1:XLEN];

   always_comb begin
      o_result = '0;
      unique case (r_op)
         OP_MUL:                        o_result = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               o_result = w_q;
         OP_REM, OP_REMU:               o_result = w_r;
         default:                       o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute unit: single-cycle ALU and bit counts, iterative
// M-extension ops, one-entry valid/ready result register.
module alu_seq
   import alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   alu_seq_if.slave  bus
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e          r_state;
   state_e          w_nxt;
   logic            r_ov;
   logic [XLEN-1:0] r_res;
   logic            r_zero;
   logic            r_ill;

   op_e             w_op;
   logic [SW-1:0]   w_sh;
   logic            w_acc;
   logic            w_dz;
   logic            w_ovf;
   logic            w_spec;
   logic            w_long;
   logic            w_go_long;
   logic            w_ill;
   logic [XLEN-1:0] w_res;
   logic            w_md_last;
   logic [XLEN-1:0] w_md_res;

   function automatic logic [XLEN-1:0] f_ctz(logic [XLEN-1:0] v);
      logic [CW-1:0] n;
      n = CW'(XLEN);
      for (int i = XLEN - 1; i >= 0; i--)
         if (v[i]) n = CW'(i);
      return XLEN'(n);
   endfunction

   function automatic logic [XLEN-1:0] f_clz(logic [XLEN-1:0] v);
      logic [CW-1:0] n;
      n = CW'(XLEN);
      for (int i = 0; i < XLEN; i++)
         if (v[i]) n = CW'(XLEN - 1 - i);
      return XLEN'(n);
   endfunction

   function automatic logic [XLEN-1:0] f_cpop(logic [XLEN-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < XLEN; i++)
         n = n + CW'(v[i]);
      return XLEN'(n);
   endfunction

   assign w_op = op_e'(bus.op);
   assign w_sh = bus.b[SW-1:0];

   assign bus.in_ready  = (r_state == IDLE) & (~r_ov | bus.out_ready);
   assign bus.out_valid = r_ov;
   assign bus.result    = r_res;
   assign bus.zero      = r_zero;
   assign bus.illegal   = r_ill;

   // Divide-by-zero and signed overflow finish in one cycle
   assign w_dz   = (bus.b == '0);
   assign w_ovf  = (w_op inside {OP_DIV, OP_REM})
                 && (bus.a == MIN) && (bus.b == '1);
   assign w_spec = is_div(w_op) && (w_dz || w_ovf);

   assign w_long    = ENABLE_M && is_long_op(w_op) && !w_spec;
   assign w_acc     = bus.in_valid & bus.in_ready & ~flush;
   assign w_go_long = w_acc & w_long;

   always_comb begin
      w_res = '0;
      w_ill = 1'b0;
      unique case (w_op)
         OP_ADD:  w_res = bus.a + bus.b;
         OP_SUB:  w_res = bus.a - bus.b;
         OP_AND:  w_res = bus.a & bus.b;
         OP_OR:   w_res = bus.a | bus.b;
         OP_XOR:  w_res = bus.a ^ bus.b;
         OP_SLL:  w_res = bus.a << w_sh;
         OP_SRL:  w_res = bus.a >> w_sh;
         OP_SRA:  w_res = $signed(bus.a) >>> w_sh;
         OP_SLT:  w_res = {{(XLEN-1){1'b0}},
                           $signed(bus.a) < $signed(bus.b)};
         OP_SLTU: w_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU:
            w_ill = !ENABLE_M;
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
            w_ill = !ENABLE_M;
            if (ENABLE_M && w_dz)
               w_res = is_rem(w_op) ? bus.a : '1;
            else if (ENABLE_M && w_ovf)
               w_res = is_rem(w_op) ? '0 : bus.a;
         end
         OP_CTZ:  w_res = f_ctz(bus.a);
         OP_CLZ:  w_res = f_clz(bus.a);
         OP_CPOP: w_res = f_cpop(bus.a);
         default: w_ill = 1'b1;
      endcase
   end

   always_comb begin
      w_nxt = r_state;
      if (flush) begin
         w_nxt = IDLE;
      end else begin
         unique case (r_state)
            IDLE:    if (w_go_long) w_nxt = ITER;
            ITER:    if (w_md_last) w_nxt = FIXUP;
            FIXUP:   w_nxt = IDLE;
            default: w_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_ov   <= 1'b0;
         r_res  <= '0;
         r_zero <= 1'b0;
         r_ill  <= 1'b0;
      end else if (w_acc && !w_long) begin
         r_ov   <= 1'b1;
         r_res  <= w_res;
         r_zero <= (w_res == '0);
         r_ill  <= w_ill;
      end else if (r_state == FIXUP) begin
         r_ov   <= 1'b1;
         r_res  <= w_md_res;
         r_zero <= (w_md_res == '0);
         r_ill  <= 1'b0;
      end else if (r_ov && bus.out_ready) begin
         r_ov   <= 1'b0;
         r_res  <= '0;
         r_zero <= 1'b0;
         r_ill  <= 1'b0;
      end
   end

   if (ENABLE_M) begin : g_md
      alu_seq_muldiv #(
         .XLEN (XLEN)
      ) u_md (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_clr    (flush),
         .i_start  (w_go_long),
         .i_step   (r_state == ITER),
         .i_op     (w_op),
         .i_a      (bus.a),
         .i_b      (bus.b),
         .o_last   (w_md_last),
         .o_result (w_md_res)
      );
   end else begin : g_nomd
      assign w_md_last = 1'b0;
      assign w_md_res  = '0;
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors, queued expectations,
// monitor compares each taken result.
module tb_alu_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   alu_seq_if #(.XLEN(32)) b1 ();
   alu_seq_if #(.XLEN(32)) b2 ();

   alu_seq #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (b1)
   );

   alu_seq #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (b2)
   );

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        zero;
      logic        ill;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   exp_t m_e;
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Monitor: one pop per taken result
   always @(negedge clk) begin
      if (rst_n && b1.out_valid && b1.out_ready) begin
         if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h, want none",
                     b1.result);
         end else begin
            m_e = sbq.pop_front();
            chk({m_e.name, ".result"}, b1.result, m_e.res);
            chk({m_e.name, ".zero"}, b1.zero, m_e.zero);
            chk({m_e.name, ".illegal"}, b1.illegal, m_e.ill);
            if (m_e.lat > 0)
               chk({m_e.name, ".latency"}, cyc - m_e.acc + 1, m_e.lat);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge
   task automatic issue(input string nm, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eill,
                        input int lat, input bit push,
                        output int waits);
      waits = 0;
      b1.op = op;
      b1.a = a;
      b1.b = b;
      b1.in_valid = 1'b1;
      @(negedge clk);
      while (!b1.in_ready && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (!b1.in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s.accept: got timeout, want in_ready", nm);
      end
      @(posedge clk);
      #1;
      b1.in_valid = 1'b0;
      if (push)
         sbq.push_back('{name: nm, res: er, zero: (er == 32'd0),
                         ill: eill, lat: lat, acc: cyc});
   endtask

   task automatic go(input string nm, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic eill,
                     input int lat);
      int w;
      issue(nm, op, a, b, er, eill, lat, 1'b1, w);
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (sbq.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(nm, sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int bad;
      int w;
      b1.in_valid = 1'b0;
      b1.op = '0;
      b1.a = '0;
      b1.b = '0;
      b1.out_ready = 1'b1;
      b2.in_valid = 1'b0;
      b2.op = '0;
      b2.a = '0;
      b2.b = '0;
      b2.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst.in_ready", b1.in_ready, 1);
      chk("rst.out_valid", b1.out_valid, 0);
      chk("rst.result", b1.result, 0);
      chk("rst.zero", b1.zero, 0);
      chk("rst.illegal", b1.illegal, 0);
      @(posedge clk);
      #1;

      go("add", OP_ADD, 32'd7, -32'sd9, 32'hFFFF_FFFE, 0, 1);
      go("sub", OP_SUB, 32'd5, 32'd5, 32'h0, 0, 1);
      go("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF,
         32'h00F0_1234, 0, 1);
      go("or", OP_OR, 32'hF000_0000, 32'h0000_000F,
         32'hF000_000F, 0, 1);
      go("xor", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F,
         32'hF0F0_0F0F, 0, 1);
      go("sll", OP_SLL, 32'd1, 32'h24, 32'h10, 0, 1);
      go("srl", OP_SRL, 32'h8000_0000, 32'd31, 32'd1, 0, 1);
      go("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1);
      go("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1);
      go("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
      drain("sb_alu");

      go("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000,
         32'h4000_0000, 0, 34);
      bad = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (b1.in_ready) bad++;
      end
      chk("mulh.in_ready_low", bad, 0);
      @(posedge clk);
      #1;
      go("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 34);
      go("mul", OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 0, 34);
      go("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,
         32'hFFFF_FFFF, 0, 34);
      go("div", OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 0, 34);
      go("rem", OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 0, 34);
      go("div_nb", OP_DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD, 0, 34);
      go("rem_nb", OP_REM, 32'd7, -32'sd2, 32'd1, 0, 34);
      go("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 0, 34);
      go("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 0, 34);
      go("divu_z", OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, 1);
      go("remu_z", OP_REMU, 32'd7, 32'd0, 32'd7, 0, 1);
      go("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1);
      go("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
         32'h8000_0000, 0, 1);
      drain("sb_m");

      b1.out_ready = 1'b0;
      go("bp_add", OP_ADD, 32'd1, 32'd2, 32'd3, 0, 0);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!b1.out_valid || b1.result !== 32'd3 || b1.in_ready)
            bad++;
      end
      chk("bp.hold", bad, 0);
      @(posedge clk);
      #1;
      b1.out_ready = 1'b1;
      issue("bp_xor", OP_XOR, 32'd5, 32'd3, 32'd6, 0, 1, 1'b1, w);
      chk("bp.same_cycle_accept", w, 0);
      @(posedge clk);
      @(negedge clk);
      chk("taken_clears", {b1.out_valid, b1.result}, 0);
      drain("sb_bp");

      issue("fl_divu", OP_DIVU, 32'd1000, 32'd3, 0, 0, 0, 1'b0, w);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush.idle", b1.in_ready, 1);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (b1.out_valid) bad++;
      end
      chk("flush.no_result", bad, 0);
      @(posedge clk);
      #1;
      flush = 1'b1;
      b1.op = OP_ADD;
      b1.a = 32'd1;
      b1.b = 32'd1;
      b1.in_valid = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      b1.in_valid = 1'b0;
      @(negedge clk);
      chk("flush.no_accept", {b1.out_valid, b1.in_ready}, 1);
      @(posedge clk);
      #1;

      issue("rs_mul", OP_MUL, 32'd3, 32'd5, 0, 0, 0, 1'b0, w);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mrst.out_valid", b1.out_valid, 0);
      chk("mrst.result", b1.result, 0);
      chk("mrst.zero", b1.zero, 0);
      chk("mrst.illegal", b1.illegal, 0);
      chk("mrst.in_ready", b1.in_ready, 1);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (b1.out_valid) bad++;
      end
      chk("mrst.no_result", bad, 0);
      @(posedge clk);
      #1;

      go("ctz", OP_CTZ, 32'h0000_0100, 32'd0, 32'd8, 0, 1);
      go("ctz0", OP_CTZ, 32'd0, 32'd0, 32'd32, 0, 1);
      go("clz", OP_CLZ, 32'd1, 32'd0, 32'd31, 0, 1);
      go("clz0", OP_CLZ, 32'd0, 32'd0, 32'd32, 0, 1);
      go("cpop", OP_CPOP, 32'hF0F0_F0F0, 32'd0, 32'd16, 0, 1);
      go("ill25", 5'd25, 32'd5, 32'd7, 32'd0, 1, 1);
      drain("sb_bits");

      b2.op = OP_MUL;
      b2.a = 32'd3;
      b2.b = 32'd5;
      b2.in_valid = 1'b1;
      @(negedge clk);
      chk("nom.in_ready", b2.in_ready, 1);
      @(posedge clk);
      #1 b2.in_valid = 1'b0;
      @(negedge clk);
      chk("nom.out_valid", b2.out_valid, 1);
      chk("nom.illegal", b2.illegal, 1);
      chk("nom.result", b2.result, 0);

      @(posedge clk);
      #1;
      drain("sb_final");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
